// File: rtl/pipelined_multiplier.sv
// Pipelined WIDTH x WIDTH multiplier with a per-operation signed/unsigned mode.
// Partial products are generated into 2*WIDTH-bit rows, reduced with a
// Dadda-style schedule of 3:2 compressors down to a sum/carry pair, and
// resolved by a final carry-propagate adder. Depending on STAGES, registers
// sit after partial-product generation, after reduction and after the final
// adder; any further stages are plain product delay registers. A single
// advance signal moves the whole pipeline, so bubbles travel like data and a
// stalled output freezes every stage.
module pipelined_multiplier #(
   parameter int WIDTH  = 24,
   parameter int STAGES = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in1,
   input  logic [WIDTH-1:0]   in2,
   input  logic               is_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out,
   output logic               busy
);

   localparam int P     = 2 * WIDTH;
   localparam int NROWS = WIDTH + 1;
   // Stages in front of the final adder output: 0, 1 (reduced pair) or 2
   // (partial products, then reduced pair).
   localparam int F     = (STAGES >= 3) ? 2 : STAGES - 1;
   // Stages from the final adder output to the output register inclusive.
   localparam int T     = STAGES - F;

   typedef logic [NROWS-1:0][P-1:0] rows_t;
   typedef logic [1:0][P-1:0]       cs_t;

   // Partial-product rows, all taken modulo 2^P. The multiplicand is sign- or
   // zero-extended to P bits. In signed mode the top multiplier bit carries
   // negative weight, so its row is the two's complement negation of the
   // shifted multiplicand: inverted row plus a one in the extra last row.
   function automatic rows_t pp_gen(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic             sgn);
      rows_t        r;
      logic [P-1:0] a_ext;
      r = '0;
      if (sgn) a_ext = {{WIDTH{a[WIDTH-1]}}, a};
      else     a_ext = {{WIDTH{1'b0}}, a};
      for (int j = 0; j < WIDTH; j++) begin
         if (b[j]) r[j] = a_ext << j;
      end
      if (sgn && b[WIDTH-1]) begin
         r[WIDTH-1] = ~(a_ext << (WIDTH-1));
         r[WIDTH]   = {{(P-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

   // Row-level Dadda reduction: at each level pick the largest height in the
   // sequence 2,3,4,6,9,13,... below the current row count and apply just
   // enough 3:2 compressors to reach it. Carries drop out of the top bit,
   // which is harmless because the product is exact within P bits.
   function automatic cs_t csa_reduce(input rows_t rows);
      rows_t cur;
      rows_t nxt;
      int    n;
      int    d;
      int    c;
      cur = rows;
      n   = NROWS;
      for (int lvl = 0; lvl < 12; lvl++) begin
         if (n > 2) begin
            d = 2;
            for (int s = 0; s < 12; s++) begin
               if ((d * 3) / 2 < n) d = (d * 3) / 2;
            end
            c   = n - d;
            nxt = '0;
            for (int i = 0; i < NROWS / 3; i++) begin
               if (i < c) begin
                  nxt[2*i]   = cur[3*i] ^ cur[3*i+1] ^ cur[3*i+2];
                  nxt[2*i+1] = ((cur[3*i] & cur[3*i+1]) |
                                (cur[3*i] & cur[3*i+2]) |
                                (cur[3*i+1] & cur[3*i+2])) << 1;
               end
            end
            for (int m = 0; m < NROWS; m++) begin
               if (m < n - 3 * c) nxt[2*c+m] = cur[3*c+m];
            end
            cur = nxt;
            n   = d;
         end
      end
      return {cur[1], cur[0]};
   endfunction

   // Final carry-propagate adder resolving the sum/carry pair.
   function automatic logic [P-1:0] final_sum(input cs_t cs);
      return cs[0] + cs[1];
   endfunction

   logic              advance;
   logic [STAGES-1:0] vld_p;
   logic [P-1:0]      prod_d;
   logic              front_vld;
   logic [P-1:0]      tail_in;
   logic              tail_vld;
   logic [P-1:0]      out_q;

   assign advance   = !vld_p[STAGES-1] || out_ready;
   assign in_ready  = advance;
   assign out_valid = vld_p[STAGES-1];
   assign out       = out_q;
   assign busy      = |vld_p;

   // Valid chain: shifts by one stage on every advance, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p <= '0;
      end else if (advance) begin
         vld_p[0] <= in_valid;
         for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   generate
      if (STAGES >= 3) begin : g_front2
         rows_t pp_p0;
         cs_t   cs_p1;
         // ---- stage 0: partial-product rows ----
         // Capture the partial products of an accepted operation.
         always_ff @(posedge clk) begin
            if (advance && in_valid) pp_p0 <= pp_gen(in1, in2, is_signed);
         end
         // ---- stage 1: reduced sum/carry pair ----
         // Reduce the registered rows to two.
         always_ff @(posedge clk) begin
            if (advance && vld_p[0]) cs_p1 <= csa_reduce(pp_p0);
         end
         assign prod_d    = final_sum(cs_p1);
         assign front_vld = vld_p[1];
      end else if (STAGES == 2) begin : g_front1
         cs_t cs_p0;
         // ---- stage 0: reduced sum/carry pair ----
         // Generate and reduce the partial products of an accepted operation.
         always_ff @(posedge clk) begin
            if (advance && in_valid) cs_p0 <= csa_reduce(pp_gen(in1, in2, is_signed));
         end
         assign prod_d    = final_sum(cs_p0);
         assign front_vld = vld_p[0];
      end else begin : g_front0
         assign prod_d    = final_sum(csa_reduce(pp_gen(in1, in2, is_signed)));
         assign front_vld = in_valid;
      end

      if (T > 1) begin : g_delay
         logic [P-1:0] dly_p [T-1];
         // ---- stages F .. STAGES-2: product delay line ----
         // Move finished products towards the output; empty slots leave data alone.
         always_ff @(posedge clk) begin
            if (advance) begin
               if (front_vld) dly_p[0] <= prod_d;
               for (int i = 1; i < T - 1; i++) begin
                  if (vld_p[F+i-1]) dly_p[i] <= dly_p[i-1];
               end
            end
         end
         assign tail_in  = dly_p[T-2];
         assign tail_vld = vld_p[STAGES-2];
      end else begin : g_nodelay
         assign tail_in  = prod_d;
         assign tail_vld = front_vld;
      end
   endgenerate

   // ---- stage STAGES-1: output register ----
   // Load only valid products so out keeps its last value across bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
      end else if (advance && tail_vld) begin
         out_q <= tail_in;
      end
   end

endmodule

// File: doc/pipelined_multiplier.md
Name: pipelined_multiplier

Overview:
- Parametrised, pipelined successor to the team's fixed-width combinational Dadda multipliers.
- Computes the exact 2*WIDTH-bit product of two WIDTH-bit operands, with a per-transaction signed/unsigned mode.
- STAGES register stages and valid/ready handshakes on both sides, so the block sits on streaming datapaths with backpressure.
- Reduction is Dadda-style, with pipeline registers inserted between the partial-product, reduction and final-adder phases.

Parameters:
WIDTH, 24, operand width in bits; legal range 4..64.
STAGES, 3, register stages from input acceptance to output; legal range 1..8.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  in1/in2/is_signed carry a valid operation this cycle.
in_ready  output  1  block accepts an operation this cycle.
in1  input  WIDTH  multiplicand.
in2  input  WIDTH  multiplier.
is_signed  input  1  1: both operands are two's complement; 0: both unsigned.
out_valid  output  1  out holds a valid product.
out_ready  input  1  downstream accepts out this cycle.
out  output  2*WIDTH  product.
busy  output  1  at least one pipeline stage holds a valid operation.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid bits clear; out_valid=0, out=0, busy=0.
  - in-flight operations are discarded and never emitted.
  - in_ready=1 while in reset, since out_valid=0.
  - First acceptance is possible on the first rising edge after rst_n deasserts.
- Advance rule:
  - advance = !out_valid || out_ready; in_ready = advance (combinational).
  - On advance, every stage shifts one position; stage 0 loads {in_valid, in1, in2, is_signed}.
  - When advance=0, all stages, including out and out_valid, hold unchanged.
- Bubbles are not collapsed; an empty slot travels like data.
- Transfers:
  - Accept = in_valid && in_ready at a rising edge.
  - Deliver = out_valid && out_ready at a rising edge.
  - in1/in2/is_signed are ignored when in_valid=0.
- Latency and ordering:
  - With out_ready held high, an operation accepted at edge k gives out_valid=1 with its product after edge k+STAGES-1 (visible in cycle k+STAGES).
  - Throughput is one operation per cycle.
  - Results leave strictly in acceptance order.
- Stability: while out_valid && !out_ready, out is bit-stable and out_valid stays 1.
- Arithmetic:
  - Unsigned: out = in1*in2, zero-extended operands.
  - Signed: out = sext(in1)*sext(in2) in 2*WIDTH-bit two's complement.
  - The result is exact; no overflow is possible, including (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2).
  - Mode travels with its operands; mixed-mode back-to-back operations are legal.
- Output and busy:
  - out keeps its last value when out_valid=0; benches must not check it then.
  - busy = OR of all stage valid bits, including out_valid.
- Simultaneous events: accept and deliver on the same edge when out_valid && out_ready && in_valid is legal and loses no data.

Test Plan:
- Reset-mid-flight: accept 3 operations with out_ready=0, assert rst_n low for 1 cycle -> out_valid=0, busy=0, out=0; none of the 3 products appear afterwards.
- Latency (WIDTH=24, STAGES=3): in1=0x000007, in2=0x000006, is_signed=0 accepted at edge k, out_ready=1 -> out_valid first high in cycle k+3, out=0x00000000002A.
- Unsigned corner: 0xFFFFFF*0xFFFFFF unsigned -> 0xFFFFFE000001. Signed corners:
  - 0xFFFFFF*0xFFFFFF -> 0x000000000001.
  - 0xFFFFFF*0x000001 -> 0xFFFFFFFFFFFF.
  - 0x800000*0x800000 -> 0x400000000000.
- Backpressure: stream 20 operations with out_ready toggling pseudo-randomly -> exactly 20 deliveries, in order, all correct; out stable whenever out_valid && !out_ready; in_ready=0 exactly when out_valid && !out_ready.
- Back-to-back mixed mode: alternate is_signed=1/0 on 0x800000*0x000002 -> alternating 0xFFFFFF000000 / 0x000001000000 at full throughput.
- Random regression (10000 operations) at WIDTH=8 STAGES=1, WIDTH=24 STAGES=3, WIDTH=32 STAGES=5 against a reference model with random in_valid/out_ready -> zero mismatches; in-flight count never exceeds STAGES.
